// File: rtl/multi_edge_detector.sv
// Multi-channel synchroniser, debounce filter and edge/event detector.
// Optional macro EDGE_DEBOUNCE_EN builds the per-channel debounce counters.
module multi_edge_detector #(
    parameter int   CHANNELS        = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] signal_in,
    input  logic [CHANNELS-1:0] flag_clear,
    output logic [CHANNELS-1:0] signal_out,
    output logic [CHANNELS-1:0] rising_edge,
    output logic [CHANNELS-1:0] falling_edge,
    output logic [CHANNELS-1:0] event_flags,
    output logic                irq
);

    if (CHANNELS < 1 || CHANNELS > 32 ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 1) begin : gBadParam
        $error("multi_edge_detector: parameter out of range");
    end

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] syncChain;
    logic [CHANNELS-1:0] syncBit;
    logic [CHANNELS-1:0] stable;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] riseNext;
    logic [CHANNELS-1:0] fallNext;

    assign syncBit    = syncChain[SYNC_STAGES-1];
    assign signal_out = stable;

    // Shift raw inputs through the metastability chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncChain <= {(SYNC_STAGES*CHANNELS){INIT_LEVEL}};
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], signal_in};
        end
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0][CNT_W-1:0] cnt;
    logic [CHANNELS-1:0][CNT_W-1:0] cntNext;

    // Count consecutive cycles of disagreement; accept on the last one.
    always_comb begin
        cntNext = '0;
        accept  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (syncBit[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cntNext[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cntNext;
        end
    end
`else
    // Without the filter every synchronised change is taken at once.
    always_comb begin
        accept = syncBit ^ stable;
    end
`endif

    // Direction of each accepted transition.
    always_comb begin
        riseNext = accept & syncBit;
        fallNext = accept & ~syncBit;
    end

    // Clean level, edge pulses, sticky flags (set beats clear) and irq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable       <= {CHANNELS{INIT_LEVEL}};
            rising_edge  <= '0;
            falling_edge <= '0;
            event_flags  <= '0;
            irq          <= 1'b0;
        end else begin
            stable       <= stable ^ accept;
            rising_edge  <= riseNext;
            falling_edge <= fallNext;
            event_flags  <= (event_flags & ~flag_clear) | riseNext | fallNext;
            irq          <= |event_flags;
        end
    end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector: synchronises `CHANNELS` asynchronous inputs (board switches, buttons, external strobes) to `clk`, optionally debounces each channel, and produces per-channel one-cycle rising/falling pulses, a clean level output, and sticky event flags with an aggregate interrupt. It sits between the board I/O pins and the user-logic blocks on the Nexys4 DDR, replacing single-channel, non-debounced edge detection.

## Interface
- `CHANNELS`, 4: number of independent input channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flops per channel (2..4).
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a level change is accepted (≥1; 10 ms at 100 MHz).
- `INIT_LEVEL`, 0: reset value of the synchroniser chain and the clean level, applied to all channels.

- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `signal_in`  in  CHANNELS  raw asynchronous inputs.
- `flag_clear`  in  CHANNELS  per-channel clear of `event_flags`, sampled on `clk`.
- `signal_out`  out  CHANNELS  synchronised, debounced level.
- `rising_edge`  out  CHANNELS  one-cycle pulse when `signal_out` goes 0→1.
- `falling_edge`  out  CHANNELS  one-cycle pulse when `signal_out` goes 1→0.
- `event_flags`  out  CHANNELS  sticky bit, set by either edge on that channel.
- `irq`  out  1  OR of all `event_flags` bits, registered.

## Operation
- Per channel: `SYNC_STAGES`-deep flop chain → `sync` bit; `stable` register drives `signal_out`.
- Debounce counter width: `$clog2(DEBOUNCE_CYCLES+1)`. Each cycle:
  - If `sync == stable`: counter ← 0.
  - Else if counter == `DEBOUNCE_CYCLES-1`: `stable` ← `sync`, counter ← 0, and the matching edge pulse is registered for one cycle.
  - Else: counter ← counter + 1.
- Any glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles returns the counter to 0 and produces no output.
- `rising_edge`/`falling_edge` are registered and mutually exclusive per channel. They are high for exactly one cycle per accepted transition.
- `event_flags[i]` is set on a rising or falling pulse and cleared when `flag_clear[i]` is high. If set and clear occur in the same cycle, set wins.
- `irq` is `|event_flags` registered, so it lags the flags by one cycle.
- Channels are fully independent, and simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset (asynchronous assert): every sync stage and `stable` ← `INIT_LEVEL`, counters ← 0, `rising_edge` = `falling_edge` = 0, `event_flags` = 0, `irq` = 0. Because `stable` equals the synchroniser contents, no spurious edge is produced after reset release.
- Reset asserted mid-debounce aborts the count. No pulse is emitted.
- Latency with the filter enabled: suppose an input change is first sampled at edge k. `signal_out` and the edge pulse update at edge k + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1, a total of `SYNC_STAGES` + `DEBOUNCE_CYCLES` edges.
- Latency with the filter disabled: `SYNC_STAGES` + 1 edges.
- `event_flags` are set on the same edge as the pulse, and `irq` rises one edge later.
- Minimum spacing between accepted transitions on one channel is `DEBOUNCE_CYCLES` cycles.

## Configuration
- `EDGE_DEBOUNCE_EN` defined: the debounce counter is built exactly as described above.
- `EDGE_DEBOUNCE_EN` undefined: the counters are not instantiated, `stable` ← `sync` every cycle, and `DEBOUNCE_CYCLES` is ignored. Every synchronised change, including one-cycle glitches, produces a pulse.

## Test plan
All scenarios use `CHANNELS`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `INIT_LEVEL`=0, and `EDGE_DEBOUNCE_EN` defined unless stated.
- Reset release with `signal_in`=4'b0000 held for 20 cycles → all outputs 0, no pulses.
- `signal_in[0]` 0→1 held, first sampled at edge k → `signal_out[0]`=1 and `rising_edge[0]` pulses for exactly 1 cycle at edge k+5. `event_flags[0]`=1 on the same edge, `irq`=1 at edge k+6.
- `signal_in[1]` high for 3 cycles, then low → no `rising_edge[1]`, `signal_out[1]` stays 0. Repeat with the macro undefined → rising pulse at edge k+2, falling pulse 3 cycles later.
- `signal_in[3:2]` 0→1 on the same cycle → `rising_edge[3:2]`=2'b11 in the same cycle. `flag_clear`=4'b0100 then clears only bit 2, and `irq` stays 1.
- `flag_clear[0]`=1 in the same cycle as a `falling_edge[0]` pulse → `event_flags[0]`=1 (set wins).
- Assert `reset` 2 cycles into a debounce of `signal_in[2]` 0→1 → all outputs 0 immediately. After release with the input still high, the rising pulse appears 6 edges later.
